// File: rtl/mem_arb_if.sv
// Bus bundle between the two requesters, the arbiter and the synchronous memory.
// LOCK0/LOCK1 exist only when MEM_ARB_LOCK_EN is defined.
interface mem_arb_if #(
  parameter int DBITS = 16
);
  logic             req0;
  logic             req1;
  logic             we0;
  logic             we1;
  logic [DBITS-1:0] addr0;
  logic [DBITS-1:0] addr1;
  logic [DBITS-1:0] din0;
  logic [DBITS-1:0] din1;
  logic             gnt0;
  logic             gnt1;
  logic             rvalid0;
  logic             rvalid1;
  logic [DBITS-1:0] rdata;
  logic [DBITS-1:0] maddr;
  logic [DBITS-1:0] mdin;
  logic             mwe;
  logic [DBITS-1:0] mdout;
`ifdef MEM_ARB_LOCK_EN
  logic             lock0;
  logic             lock1;

  modport master (
    output req0, req1, we0, we1, addr0, addr1, din0, din1, lock0, lock1, mdout,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata, maddr, mdin, mwe
  );

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, din0, din1, lock0, lock1, mdout,
    output gnt0, gnt1, rvalid0, rvalid1, rdata, maddr, mdin, mwe
  );
`else
  modport master (
    output req0, req1, we0, we1, addr0, addr1, din0, din1, mdout,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata, maddr, mdin, mwe
  );

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, din0, din1, mdout,
    output gnt0, gnt1, rvalid0, rvalid1, rdata, maddr, mdin, mwe
  );
`endif
endinterface

// File: rtl/mem_arb.sv
// Two-port round-robin arbiter in front of a single synchronous memory (1-cycle read).
// Optional grant locking with a MAXLOCK run limit is compiled in by MEM_ARB_LOCK_EN.
module mem_arb #(
  parameter int DBITS   = 16,
  parameter int MAXLOCK = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  mem_arb_if.slave bus
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_e;

  state_e           state_q, state_d;
  logic             last_q, last_d;
  logic             rd_q, rd_d;
  logic [DBITS-1:0] maddr_q, maddr_d;
  logic [DBITS-1:0] mdin_q, mdin_d;
  logic             gnt0, gnt1;
  logic             hold0, hold1;

  // MAXLOCK below 1 is meaningless; this empty block only anchors the parameter.
  if (MAXLOCK < 1) begin : g_maxlock_invalid
  end

`ifdef MEM_ARB_LOCK_EN
  localparam int            CW   = $clog2(MAXLOCK + 1);
  localparam logic [CW-1:0] MAXC = CW'(MAXLOCK);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          gnt_lock;
  logic          same_owner;

  // A nonzero count means the owner's previous grant was locked.
  assign hold0 = (state_q == OWN0) && (cnt_q != '0) && (cnt_q != MAXC) && bus.req0;
  assign hold1 = (state_q == OWN1) && (cnt_q != '0) && (cnt_q != MAXC) && bus.req1;

  assign gnt_lock   = (gnt0 && bus.lock0) || (gnt1 && bus.lock1);
  assign same_owner = (gnt0 && state_q == OWN0) || (gnt1 && state_q == OWN1);

  always_comb begin
    cnt_d = '0;
    if (gnt_lock) begin
      if (!same_owner)
        cnt_d = CW'(1);
      else if (cnt_q == MAXC)
        cnt_d = '0;
      else
        cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end
`else
  assign hold0 = 1'b0;
  assign hold1 = 1'b0;
`endif

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n) begin
      if (hold0) begin
        gnt0 = 1'b1;
      end else if (hold1) begin
        gnt1 = 1'b1;
      end else if (bus.req0 && bus.req1) begin
        gnt0 = last_q;
        gnt1 = !last_q;
      end else begin
        gnt0 = bus.req0;
        gnt1 = bus.req1;
      end
    end
  end

  always_comb begin
    state_d = IDLE;
    last_d  = last_q;
    rd_d    = 1'b0;
    maddr_d = maddr_q;
    mdin_d  = mdin_q;
    if (gnt0) begin
      state_d = OWN0;
      last_d  = 1'b0;
      rd_d    = !bus.we0;
      maddr_d = bus.addr0;
      mdin_d  = bus.din0;
    end else if (gnt1) begin
      state_d = OWN1;
      last_d  = 1'b1;
      rd_d    = !bus.we1;
      maddr_d = bus.addr1;
      mdin_d  = bus.din1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      rd_q    <= 1'b0;
      maddr_q <= '0;
      mdin_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      rd_q    <= rd_d;
      maddr_q <= maddr_d;
      mdin_q  <= mdin_d;
    end
  end

  assign bus.gnt0    = gnt0;
  assign bus.gnt1    = gnt1;
  assign bus.mwe     = (gnt0 && bus.we0) || (gnt1 && bus.we1);
  assign bus.maddr   = maddr_d;
  assign bus.mdin    = mdin_d;
  // The memory answers one cycle after the address, so RDATA is a straight pass-through.
  assign bus.rdata   = bus.mdout;
  assign bus.rvalid0 = (state_q == OWN0) && rd_q;
  assign bus.rvalid1 = (state_q == OWN1) && rd_q;

endmodule

// File: tb/tb_mem_arb.sv
// Randomised bench for mem_arb: a transaction-level model predicts grants, memory-side
// signals and read data each cycle; directed sequences pin the model with literal values.
module tb_mem_arb;

  localparam int DBITS   = 16;
  localparam int MAXLOCK = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_arb_if #(.DBITS(DBITS)) bus();

  mem_arb #(.DBITS(DBITS), .MAXLOCK(MAXLOCK)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  // Synchronous memory behind the arbiter.
  logic [DBITS-1:0] mem [0:255] = '{default: '0};
  always @(posedge clk) begin
    if (bus.mwe) mem[bus.maddr[7:0]] <= bus.mdin;
    bus.mdout <= mem[bus.maddr[7:0]];
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  logic [DBITS-1:0] ref_mem [0:255] = '{default: '0};
  int               m_last  = 1;
  int               m_owner = -1;
  int               m_run   = 0;
  logic             m_rv0   = 1'b0;
  logic             m_rv1   = 1'b0;
  logic [DBITS-1:0] m_rdata = '0;
  logic [DBITS-1:0] m_maddr = '0;
  logic [DBITS-1:0] m_mdin  = '0;

  always @(negedge clk) begin : model
    int               w;
    logic [1:0]       rq;
    logic [1:0]       lk;
    logic             we [2];
    logic [DBITS-1:0] a  [2];
    logic [DBITS-1:0] d  [2];
    rq = {bus.req1, bus.req0};
    lk = 2'b00;
`ifdef MEM_ARB_LOCK_EN
    lk = {bus.lock1, bus.lock0};
`endif
    we[0] = bus.we0;  we[1] = bus.we1;
    a[0]  = bus.addr0; a[1] = bus.addr1;
    d[0]  = bus.din0;  d[1] = bus.din1;
    if (!rst_n) begin
      m_last = 1; m_owner = -1; m_run = 0;
      m_rv0 = 1'b0; m_rv1 = 1'b0; m_maddr = '0; m_mdin = '0;
      chk("m_rst_gnt", {bus.gnt1, bus.gnt0}, 0);
      chk("m_rst_mwe", bus.mwe, 0);
      chk("m_rst_rvalid", {bus.rvalid1, bus.rvalid0}, 0);
      chk("m_rst_maddr", bus.maddr, 0);
    end else begin
      w = -1;
      if (m_owner >= 0 && m_run > 0 && m_run < MAXLOCK && rq[m_owner]) w = m_owner;
      else if (rq == 2'b11) w = 1 - m_last;
      else if (rq[0]) w = 0;
      else if (rq[1]) w = 1;
      chk("m_gnt0", bus.gnt0, (w == 0));
      chk("m_gnt1", bus.gnt1, (w == 1));
      chk("m_mwe", bus.mwe, (w >= 0) && we[w]);
      if (w >= 0) begin
        m_maddr = a[w];
        m_mdin  = d[w];
      end
      chk("m_maddr", bus.maddr, m_maddr);
      chk("m_mdin", bus.mdin, m_mdin);
      chk("m_rvalid0", bus.rvalid0, m_rv0);
      chk("m_rvalid1", bus.rvalid1, m_rv1);
      if (m_rv0 || m_rv1) chk("m_rdata", bus.rdata, m_rdata);
      // advance the model across the coming edge
      m_rv0 = (w == 0) && !we[0];
      m_rv1 = (w == 1) && !we[1];
      if (w >= 0) begin
        if (we[w]) ref_mem[a[w][7:0]] = d[w];
        else       m_rdata = ref_mem[a[w][7:0]];
        if (!lk[w])                              m_run = 0;
        else if (w == m_owner && m_run >= MAXLOCK) m_run = 0;
        else if (w == m_owner && m_run > 0)        m_run = m_run + 1;
        else                                       m_run = 1;
        m_owner = w;
        m_last  = w;
      end else begin
        m_owner = -1;
        m_run   = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  logic g0s, g1s, exp1;

  initial begin
    bus.req0 = 1'b1; bus.req1 = 1'b1; bus.we0 = 1'b0; bus.we1 = 1'b0;
    bus.addr0 = 16'h0001; bus.addr1 = 16'h0002; bus.din0 = '0; bus.din1 = '0;
`ifdef MEM_ARB_LOCK_EN
    bus.lock0 = 1'b0; bus.lock1 = 1'b0;
`endif
    rst_n = 1'b0;

    // reset state with both requests high
    repeat (2) begin
      @(negedge clk);
      chk("rst_gnt0", bus.gnt0, 0);
      chk("rst_gnt1", bus.gnt1, 0);
      chk("rst_mwe", bus.mwe, 0);
      chk("rst_mdin", bus.mdin, 0);
      chk("rst_rvalid0", bus.rvalid0, 0);
    end

    // both read: port 0 first, then alternate
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk); chk("c1_gnt0", bus.gnt0, 1); chk("c1_gnt1", bus.gnt1, 0);
    @(posedge clk); #1;
    @(negedge clk); chk("c2_gnt1", bus.gnt1, 1); chk("c2_rvalid0", bus.rvalid0, 1);
    chk("c2_rvalid1", bus.rvalid1, 0);
    @(posedge clk); #1;
    @(negedge clk); chk("c3_gnt0", bus.gnt0, 1); chk("c3_rvalid1", bus.rvalid1, 1);
    chk("c3_rvalid0", bus.rvalid0, 0);

    // lone write on port 1 then read-back on port 0
    @(posedge clk); #1;
    bus.req0 = 1'b0; bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 16'h0010; bus.din1 = 16'hBEEF;
    @(negedge clk);
    chk("wr_gnt1", bus.gnt1, 1); chk("wr_mwe", bus.mwe, 1);
    chk("wr_maddr", bus.maddr, 16'h0010); chk("wr_mdin", bus.mdin, 16'hBEEF);
    @(posedge clk); #1;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 16'h0010;
    @(negedge clk);
    chk("rd_gnt0", bus.gnt0, 1); chk("wr_no_rvalid1", bus.rvalid1, 0); chk("rd_mwe", bus.mwe, 0);
    @(posedge clk); #1; bus.req0 = 1'b0;
    @(negedge clk);
    chk("rd_rvalid0", bus.rvalid0, 1); chk("rd_rdata", bus.rdata, 16'hBEEF);
    chk("idle_maddr_hold", bus.maddr, 16'h0010); chk("idle_mwe", bus.mwe, 0);

    // reset right after a granted read
    @(posedge clk); #1; bus.req0 = 1'b1; bus.addr0 = 16'h0003;
    @(negedge clk); chk("pre_rst_gnt0", bus.gnt0, 1);
    @(posedge clk); #1; rst_n = 1'b0; bus.req1 = 1'b1;
    @(negedge clk);
    chk("midrst_rvalid0", bus.rvalid0, 0);
    chk("midrst_gnt0", bus.gnt0, 0); chk("midrst_gnt1", bus.gnt1, 0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk); chk("post_rst_gnt0", bus.gnt0, 1); chk("post_rst_gnt1", bus.gnt1, 0);

    // continuous contention, port 1 requesting lock when compiled in
    @(posedge clk); #1; rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    bus.req0 = 1'b1; bus.req1 = 1'b1; bus.we0 = 1'b0; bus.we1 = 1'b0;
`ifdef MEM_ARB_LOCK_EN
    bus.lock1 = 1'b1;
`endif
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
`ifdef MEM_ARB_LOCK_EN
      exp1 = (i % 5) != 0;
`else
      exp1 = (i % 2) == 1;
`endif
      chk("seq_gnt1", bus.gnt1, exp1);
      chk("seq_gnt0", bus.gnt0, !exp1);
      @(posedge clk); #1;
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
`ifdef MEM_ARB_LOCK_EN
    bus.lock1 = 1'b0;
`endif

    // random traffic, requesters hold until granted, occasional withdrawal and reset
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk); g0s = bus.gnt0; g1s = bus.gnt1;
      @(posedge clk); #1;
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 199) == 0) rst_n = 1'b0;
      if (!bus.req0 || g0s) begin
        bus.req0  = $urandom_range(0, 9) < 7;
        bus.we0   = $urandom_range(0, 2) == 0;
        bus.addr0 = 16'($urandom_range(0, 31));
        bus.din0  = 16'($urandom);
      end else if ($urandom_range(0, 19) == 0) begin
        bus.req0 = 1'b0;
      end
      if (!bus.req1 || g1s) begin
        bus.req1  = $urandom_range(0, 9) < 7;
        bus.we1   = $urandom_range(0, 2) == 0;
        bus.addr1 = 16'($urandom_range(0, 31));
        bus.din1  = 16'($urandom);
      end else if ($urandom_range(0, 19) == 0) begin
        bus.req1 = 1'b0;
      end
`ifdef MEM_ARB_LOCK_EN
      bus.lock0 = $urandom_range(0, 3) == 0;
      bus.lock1 = $urandom_range(0, 1) == 0;
`endif
    end

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001: Parameter DBITS, default 16, data and address width.
REQ-002: Parameter MAXLOCK, default 4, maximum consecutive cycles of a locked grant; used only with MEM_ARB_LOCK_EN.
REQ-003: CLK  input  1  single clock; all state updates on posedge.
REQ-004: RST_N  input  1  reset, asynchronous, active-low.
REQ-005: REQ0, REQ1  input  1 each  transaction request; port 0 is the CPU, port 1 is the debug/DMA requester.
REQ-006: WE0, WE1  input  1 each  1 = write, 0 = read; sampled with REQx.
REQ-007: ADDR0, ADDR1  input  DBITS each  byte address.
REQ-008: DIN0, DIN1  input  DBITS each  write data.
REQ-009: GNT0, GNT1  output  1 each  combinational grant; the request is accepted this cycle.
REQ-010: RVALID0, RVALID1  output  1 each  registered; read data valid on RDATA.
REQ-011: RDATA  output  DBITS  read data, shared by both ports.
REQ-012: MADDR, MDIN  output  DBITS each  memory-side address and write data.
REQ-013: MWE  output  1  memory-side write enable.
REQ-014: MDOUT  input  DBITS  memory-side read data, synchronous, valid one cycle after the address.
REQ-015: LOCK0, LOCK1  input  1 each  hold grant; present only with MEM_ARB_LOCK_EN.

Function
REQ-016: At most one GNTx is high in any cycle; GNTx is never high while REQx is low.
REQ-017: One request only -> grant that port in the same cycle.
REQ-018: Both request -> grant the port not in register LAST; after every grant, LAST <= granted port index.
REQ-019: When GNTx is high, MADDR = ADDRx, MDIN = DINx, MWE = WEx; when neither port is granted, MWE = 0 and MADDR/MDIN hold their last driven values.
REQ-020: A granted read (WEx = 0) -> RVALIDx = 1 for exactly the next cycle, with RDATA = MDOUT; read latency is 1 cycle.
REQ-021: A granted write produces no RVALID.
REQ-022: Back-to-back grants are legal: a read on cycle N and a grant on N+1 both complete, with RVALID on N+1 and N+2 respectively.
REQ-023: When RVALID0 and RVALID1 are both low, RDATA = MDOUT (pass-through, don't-care to requesters).
REQ-024: A requester holds REQx, WEx, ADDRx and DINx stable until it sees GNTx; dropping REQx before a grant withdraws the request without side effects.
REQ-025: State FSM: IDLE (no owner), OWN0, OWN1; next state = the port granted this cycle, else IDLE; the FSM drives RVALID and lock tracking.

Reset
REQ-026: RST_N low asynchronously sets FSM = IDLE, LAST = 1 (port 0 wins the first tie), RVALID0 = RVALID1 = 0, lock counter = 0, and MADDR = MDIN = 0.
REQ-027: While RST_N is low, GNT0 = GNT1 = 0 and MWE = 0 regardless of inputs.
REQ-028: Reset asserted the cycle after a granted read suppresses its RVALID; no transaction is replayed after reset release.

Configuration
REQ-029: Macro MEM_ARB_LOCK_EN compiles in LOCK0/LOCK1 and a lock counter of ceil(log2(MAXLOCK+1)) bits.
REQ-030: With the macro, if port x is granted with LOCKx = 1 and REQx is still high on the next cycle, port x is granted again regardless of REQ of the other port.
REQ-031: The counter increments per consecutive locked grant; at MAXLOCK consecutive grants, lock is ignored for one arbitration and the REQ-018 rule applies, then the counter clears.
REQ-032: The counter clears whenever the owner changes or the bus goes idle.
REQ-033: Without the macro, the LOCK ports and counter do not exist and arbitration is pure round-robin per REQ-017/018.

Verification
REQ-034: Reset release, REQ0 = REQ1 = 1 (both read) -> GNT0 on cycle 1, GNT1 on cycle 2, alternating thereafter; RVALID0 on 2, RVALID1 on 3.
REQ-035: REQ1 write ADDR1 = 16'h0010, DIN1 = 16'hBEEF alone -> GNT1 same cycle, MWE = 1, MADDR = 16'h0010, MDIN = 16'hBEEF, no RVALID1.
REQ-036: Port 0 reads 16'h0010 the cycle after the REQ-035 write (model memory) -> RVALID0 next cycle with RDATA = 16'hBEEF.
REQ-037: RST_N pulled low the cycle after GNT0 for a read -> RVALID0 stays 0, GNT0 = GNT1 = 0 during reset, and the first tie after release goes to port 0.
REQ-038: MEM_ARB_LOCK_EN, MAXLOCK = 4, REQ1 = LOCK1 = 1 and REQ0 = 1 continuously -> GNT1 for 4 cycles, GNT0 on cycle 5, then GNT1 for 4 cycles again.
REQ-039: Without the macro, the same stimulus as REQ-038 -> strict alternation GNT0/GNT1 every cycle.
